// File: rtl/hex_display_sequencer.sv
// rtl/hex_display_sequencer.sv - arbitrates two hex-value requesters onto an Avalon-MM seven-segment PIO write
// Optional readback verification of each write is enabled by defining HEX_READBACK_VERIFY_EN.
module hex_display_sequencer #(
    parameter logic [1:0] PIO_ADDR = 2'd0,
    parameter int         TIMEOUT  = 64
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        req0_valid,
    input  logic [15:0] req0_value,
    input  logic [3:0]  req0_dp,
    output logic        req0_ready,

    input  logic        req1_valid,
    input  logic [15:0] req1_value,
    input  logic [3:0]  req1_dp,
    output logic        req1_ready,

    output logic [1:0]  m_address,
    output logic        m_chipselect,
    output logic        m_write_n,
    output logic [31:0] m_writedata,
    input  logic        m_waitrequest,
    input  logic [31:0] m_readdata,

    output logic        busy,
    output logic        last_grant,
    output logic        err_timeout,
    output logic        err_verify
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
`ifdef HEX_READBACK_VERIFY_EN
    localparam logic [1:0] S_READ  = 2'd2;
`endif

    // Abort fires on the stalled edge that would make the count reach TIMEOUT.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    logic [1:0] state;
    logic [7:0] wait_cnt;
    logic       grant_any;
    logic       grant_id;
    logic       accept;
    logic       stall_abort;

    // Active-low segments, bit0 = a .. bit6 = g.
    function automatic logic [6:0] seg7(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    function automatic logic [31:0] encode(input logic [15:0] value, input logic [3:0] dp);
        logic [31:0] word;
        word = '0;
        for (int k = 0; k < 4; k++) begin
            word[8*k +: 8] = {~dp[k], seg7(value[4*k +: 4])};
        end
        return word;
    endfunction

    always_comb begin
        grant_any = req0_valid | req1_valid;
        grant_id  = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_id = ~last_grant;
        end else begin
            grant_id = req1_valid;
        end
    end

    // Ready is a combinational accept strobe; reset_n gating keeps it low while reset is held.
    assign accept      = reset_n && (state == S_IDLE) && grant_any;
    assign req0_ready  = accept && !grant_id;
    assign req1_ready  = accept && grant_id;
    assign stall_abort = m_waitrequest && (wait_cnt == WAIT_LAST);

    assign m_address    = PIO_ADDR;
    assign m_chipselect = (state != S_IDLE);
    assign m_write_n    = (state != S_WRITE);
    assign busy         = (state != S_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            wait_cnt    <= 8'd0;
            m_writedata <= 32'd0;
            last_grant  <= 1'b1;
            err_timeout <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        last_grant  <= grant_id;
                        m_writedata <= grant_id ? encode(req1_value, req1_dp)
                                                : encode(req0_value, req0_dp);
                        wait_cnt    <= 8'd0;
                        state       <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (!m_waitrequest) begin
                        err_timeout <= 1'b0;
`ifdef HEX_READBACK_VERIFY_EN
                        wait_cnt    <= 8'd0;
                        state       <= S_READ;
`else
                        state       <= S_IDLE;
`endif
                    end else if (stall_abort) begin
                        err_timeout <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
`ifdef HEX_READBACK_VERIFY_EN
                S_READ: begin
                    if (!m_waitrequest) begin
                        state <= S_IDLE;
                    end else if (stall_abort) begin
                        err_timeout <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
`endif
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef HEX_READBACK_VERIFY_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_verify <= 1'b0;
        end else if (state == S_READ && !m_waitrequest) begin
            err_verify <= (m_readdata != m_writedata);
        end
    end
`else
    logic unused_readdata;
    assign unused_readdata = ^m_readdata;
    assign err_verify      = 1'b0;
`endif

endmodule
